// File: rtl/fsmc_acq_pkg.sv
// Shared types and default sizing for the FSMC acquisition sequencer.
// No logic: type and constant definitions only.
// Not applicable: no flow control in this package.
package fsmc_acq_pkg;

    localparam int DEPTH_DEF     = 10000;
    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 12;
    localparam int PULSE_LEN_DEF = 8;
    localparam int TIMEOUT_DEF   = 65535;
    localparam int FSMC_W        = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_CAPTURE,
        ST_READOUT
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 clocks from pin change to o_q.
// No backpressure; the input is sampled every cycle.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Metastability chain; reset value matches the pin's idle level so reset release makes no false edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/fsmc_acq_sequencer.sv
// Sequences pulse -> capture DEPTH samples -> serve them to the MCU one word per NOE fall.
// Latency: pulse 3 clocks after START pin edge; read index moves 3 clocks after NOE falls, word 2 later.
// No backpressure: capture follows cap_valid; readout paced by NOE with a timeout abort.
module fsmc_acq_sequencer
    import fsmc_acq_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PULSE_LEN = PULSE_LEN_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              DCLK,
    input  logic              RST,
    input  logic              START_FGPA,
    input  logic              FGPA_OE,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_data,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_waddr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic [ADDR_W-1:0] buf_raddr,
    input  logic [DATA_W-1:0] buf_rdata,
    output logic              ema_pulse,
    output logic              fsmc_dir,
    output logic [FSMC_W-1:0] fsmc_out,
    output logic              data_ready,
    output logic              busy,
    output logic              err_timeout
);

    localparam int PC_W  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_start_s2;
    logic              w_oe_s2;
    logic              r_start_s3;
    logic              r_oe_s3;
    logic              w_start_rise;
    logic              w_oe_fall;
    logic [ADDR_W-1:0] r_wr_idx;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [PC_W-1:0]   r_pulse_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_err;
    logic [FSMC_W-1:0] r_fsmc_out;
    logic              w_pulse_done;
    logic              w_cap_last;
    logic              w_rd_last;
    logic              w_tmo_hit;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_start (
        .i_clk (DCLK),
        .i_rst (RST),
        .i_d   (START_FGPA),
        .o_q   (w_start_s2)
    );

    sync_2ff #(.RST_VAL(1'b1)) u_sync_oe (
        .i_clk (DCLK),
        .i_rst (RST),
        .i_d   (FGPA_OE),
        .o_q   (w_oe_s2)
    );

    // History stage behind each synchroniser for edge detection.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            r_start_s3 <= 1'b0;
            r_oe_s3    <= 1'b1;
        end else begin
            r_start_s3 <= w_start_s2;
            r_oe_s3    <= w_oe_s2;
        end
    end

    assign w_start_rise = w_start_s2 & ~r_start_s3;
    assign w_oe_fall    = r_oe_s3 & ~w_oe_s2;

    assign w_pulse_done = (r_pulse_cnt == PC_W'(PULSE_LEN - 1));
    assign w_cap_last   = cap_valid && (r_wr_idx == ADDR_W'(DEPTH - 1));
    assign w_rd_last    = w_oe_fall && (r_rd_idx == ADDR_W'(DEPTH - 1));
    // An NOE fall in the limit cycle counts as activity, so the final read beats the timeout.
    assign w_tmo_hit    = !w_oe_fall && (r_tmo_cnt == TMO_W'(TIMEOUT));

    // State register.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; START is only honoured from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_rise) w_state_nxt = ST_PULSE;
            ST_PULSE:   if (w_pulse_done) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_cap_last)   w_state_nxt = ST_READOUT;
            ST_READOUT: if (w_rd_last || w_tmo_hit) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state counters and the sticky timeout flag; indices wrap to 0 on completion.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_pulse_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_wr_idx    <= '0;
                        r_rd_idx    <= '0;
                        r_pulse_cnt <= '0;
                        r_tmo_cnt   <= '0;
                        r_err       <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    r_pulse_cnt <= w_pulse_done ? '0 : r_pulse_cnt + PC_W'(1);
                end
                ST_CAPTURE: begin
                    if (cap_valid) begin
                        r_wr_idx <= w_cap_last ? '0 : r_wr_idx + ADDR_W'(1);
                    end
                end
                ST_READOUT: begin
                    if (w_oe_fall) begin
                        r_rd_idx  <= w_rd_last ? '0 : r_rd_idx + ADDR_W'(1);
                        r_tmo_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_rd_idx  <= '0;
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output word register: follows the buffer every cycle while serving, zero otherwise.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            r_fsmc_out <= '0;
        end else if (r_state == ST_READOUT) begin
            r_fsmc_out <= FSMC_W'(buf_rdata);
        end else begin
            r_fsmc_out <= '0;
        end
    end

    assign ema_pulse   = (r_state == ST_PULSE);
    assign buf_we      = (r_state == ST_CAPTURE) && cap_valid;
    assign buf_waddr   = r_wr_idx;
    assign buf_wdata   = (r_state == ST_CAPTURE) ? cap_data : '0;
    assign buf_raddr   = r_rd_idx;
    assign fsmc_dir    = (r_state == ST_READOUT);
    assign data_ready  = (r_state == ST_READOUT);
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err;
    assign fsmc_out    = r_fsmc_out;

endmodule

// File: tb/tb_fsmc_acq_sequencer.sv
// Bench for fsmc_acq_sequencer: random capture data/gaps, modelled sample RAM, MCU read model.
// Expected writes and read words go to queues; monitors compare on buf_we and on MCU sample strobes.
// Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
module tb_fsmc_acq_sequencer;

    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 12;
    localparam int PULSE_LEN = 4;
    localparam int TIMEOUT   = 20;

    logic              DCLK = 1'b0;
    logic              RST;
    logic              START_FGPA;
    logic              FGPA_OE;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_data;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [DATA_W-1:0] buf_wdata;
    logic [ADDR_W-1:0] buf_raddr;
    logic [DATA_W-1:0] buf_rdata = '0;
    logic              ema_pulse;
    logic              fsmc_dir;
    logic [15:0]       fsmc_out;
    logic              data_ready;
    logic              busy;
    logic              err_timeout;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               wq [$];
    logic [15:0]       rq [$];
    logic [DATA_W-1:0] ref_buf [DEPTH];
    logic              mcu_strobe = 1'b0;
    int                tests = 0;
    int                fails = 0;
    int                ema_cnt = 0;
    logic              ema_prev = 1'b0;

    always #5 DCLK = ~DCLK;

    fsmc_acq_sequencer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .PULSE_LEN (PULSE_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .DCLK        (DCLK),
        .RST         (RST),
        .START_FGPA  (START_FGPA),
        .FGPA_OE     (FGPA_OE),
        .cap_valid   (cap_valid),
        .cap_data    (cap_data),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .buf_raddr   (buf_raddr),
        .buf_rdata   (buf_rdata),
        .ema_pulse   (ema_pulse),
        .fsmc_dir    (fsmc_dir),
        .fsmc_out    (fsmc_out),
        .data_ready  (data_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    // External sample RAM: synchronous write, one-cycle registered read.
    always @(posedge DCLK) begin
        if (buf_we) mem[buf_waddr] <= buf_wdata;
        buf_rdata <= mem[buf_raddr];
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Write monitor: every buffer write must match the next expected (address, data).
    always @(negedge DCLK) begin
        if (!RST && buf_we) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got write addr %0d data 0x%0h, expected none", buf_waddr, buf_wdata);
            end else begin
                chk("write", {buf_waddr, buf_wdata}, wq.pop_front());
            end
        end
    end

    // Read monitor: each MCU sample must see the next expected word.
    always @(negedge DCLK) begin
        if (mcu_strobe) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got word 0x%0h, expected no sample", fsmc_out);
            end else begin
                chk("read_word", 32'(fsmc_out), 32'(rq.pop_front()));
            end
        end
    end

    // Excitation pulse width monitor.
    always @(negedge DCLK) begin
        if (ema_pulse) begin
            ema_cnt++;
        end else if (ema_prev) begin
            chk("ema_len", ema_cnt, PULSE_LEN);
            ema_cnt = 0;
        end
        ema_prev = ema_pulse;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge DCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ema"},   ema_pulse,   0);
        chk({tag, "_we"},    buf_we,      0);
        chk({tag, "_waddr"}, buf_waddr,   0);
        chk({tag, "_wdata"}, buf_wdata,   0);
        chk({tag, "_raddr"}, buf_raddr,   0);
        chk({tag, "_dir"},   fsmc_dir,    0);
        chk({tag, "_out"},   fsmc_out,    0);
        chk({tag, "_ready"}, data_ready,  0);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_err"},   err_timeout, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy,       0);
        chk({tag, "_ready"}, data_ready, 0);
        chk({tag, "_dir"},   fsmc_dir,   0);
    endtask

    // Start an acquisition and feed DEPTH samples; seq_data uses i+1, else random data.
    task automatic start_acq(input bit seq_data, input bit poke);
        int                lat;
        bit                left_pulse;
        logic [DATA_W-1:0] d;
        START_FGPA = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ema_pulse) begin
                lat = i;
                break;
            end
        end
        chk("ema_latency", lat, 3);
        chk("err_clear_on_start", err_timeout, 0);
        chk("busy_in_pulse", busy, 1);
        START_FGPA = 1'b0;
        // Random strobes during the pulse must not reach the buffer.
        left_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ema_pulse) begin
                left_pulse = 1'b1;
                break;
            end
            cap_valid = 1'($urandom_range(0, 1));
            cap_data  = DATA_W'($urandom);
            tick();
        end
        cap_valid = 1'b0;
        chk("pulse_ended", left_pulse, 1);
        for (int i = 0; i < DEPTH; i++) begin
            ticks($urandom_range(0, 2));
            if (poke && i == 2) START_FGPA = 1'b1;
            if (poke && i == 5) START_FGPA = 1'b0;
            d = seq_data ? DATA_W'(i + 1) : DATA_W'($urandom);
            ref_buf[i] = d;
            wq.push_back(wr_t'{a: ADDR_W'(i), d: d});
            cap_valid = 1'b1;
            cap_data  = d;
            tick();
            cap_valid = 1'b0;
        end
        START_FGPA = 1'b0;
        ticks(2);
        chk("writes_drained", wq.size(), 0);
    endtask

    task automatic sample(input int k);
        rq.push_back(16'(ref_buf[k]));
        mcu_strobe = 1'b1;
        tick();
        mcu_strobe = 1'b0;
    endtask

    // MCU model: read word 0, then per NOE fall wait 6 clocks and read the next word.
    task automatic mcu_readout(input int n_falls, input int last_gap, input bit poke);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (data_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("data_ready_seen", ok, 1);
        chk("fsmc_dir_readout", fsmc_dir, 1);
        ticks(3);
        sample(0);
        for (int k = 1; k <= n_falls; k++) begin
            FGPA_OE = 1'b0;
            if (poke && k == 3) START_FGPA = 1'b1;
            if (poke && k == 4) START_FGPA = 1'b0;
            ticks(2);
            FGPA_OE = 1'b1;
            ticks(4);
            if (k < DEPTH) sample(k);
            else tick();
            if (k < n_falls) ticks(((k == n_falls - 1) ? last_gap : 8) - 7);
        end
        START_FGPA = 1'b0;
    endtask

    initial begin
        int  w;
        bit  ok;
        RST        = 1'b1;
        START_FGPA = 1'b0;
        FGPA_OE    = 1'b1;
        cap_valid  = 1'b0;
        cap_data   = '0;
        ticks(3);
        chk_all_zero("reset");
        RST = 1'b0;
        ticks(5);
        chk_idle("after_reset");
        chk("after_reset_raddr", buf_raddr, 0);

        // Full cycle with i+1 data; START poked during capture and readout.
        start_acq(1'b1, 1'b1);
        mcu_readout(DEPTH, 8, 1'b1);
        ticks(4);
        chk_idle("full_cycle");
        chk("full_cycle_err", err_timeout, 0);

        // Timeout after 3 reads with NOE held high.
        start_acq(1'b0, 1'b0);
        mcu_readout(3, 8, 1'b0);
        ok = 1'b0;
        w  = 0;
        for (int i = 0; i < 60; i++) begin
            if (err_timeout) begin
                ok = 1'b1;
                break;
            end
            tick();
            w++;
        end
        chk("timeout_fired", ok, 1);
        chk("timeout_window", ((7 + w) >= TIMEOUT) && ((7 + w) <= TIMEOUT + 6), 1);
        chk_idle("timeout");
        ticks(5);
        chk("timeout_sticky", err_timeout, 1);

        // Next START clears the flag; final fall lands exactly on the timeout limit.
        start_acq(1'b0, 1'b0);
        mcu_readout(DEPTH, TIMEOUT + 1, 1'b0);
        ticks(4);
        chk_idle("coincide");
        chk("coincide_err", err_timeout, 0);

        // Reset mid-readout at rd_idx 5, then a fresh acquisition reads from index 0.
        start_acq(1'b0, 1'b0);
        mcu_readout(5, 8, 1'b0);
        chk("mid_readout_raddr", buf_raddr, 5);
        RST = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        ticks(2);
        RST = 1'b0;
        ticks(3);
        start_acq(1'b0, 1'b0);
        mcu_readout(DEPTH, 8, 1'b0);
        ticks(4);
        chk_idle("after_mid_rst");
        chk("after_mid_rst_err", err_timeout, 0);
        chk("reads_drained", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
